// File: rtl/generic_bus_arbiter.sv
// Round-robin N-to-1 arbiter for the generic bus: one registered grant is held per transfer.
// Optional transfer watchdog is enabled by defining GENERIC_BUS_ARB_TIMEOUT_EN.
module generic_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0]   m_byte_en,
    input  logic [NUM_MASTERS-1:0]            m_ren,
    input  logic [NUM_MASTERS-1:0]            m_wen,
    output logic [NUM_MASTERS*DATA_W-1:0]     m_rdata,
    output logic [NUM_MASTERS-1:0]            m_busy,
    output logic [NUM_MASTERS-1:0]            m_error,
    output logic [ADDR_W-1:0]                 s_addr,
    output logic [DATA_W-1:0]                 s_wdata,
    output logic [DATA_W/8-1:0]               s_byte_en,
    output logic                              s_ren,
    output logic                              s_wen,
    input  logic [DATA_W-1:0]                 s_rdata,
    input  logic                              s_busy,
    input  logic                              s_error
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("generic_bus_arbiter: illegal parameter value");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       gnt;
    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       winner;
    logic [NUM_MASTERS-1:0] req;
    logic                   done;
    logic                   tmo;

`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    assign tmo = (state == GRANT) & s_busy & (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign tmo = 1'b0;
`endif

    assign req  = m_ren | m_wen;
    assign done = (state == GRANT) & ~s_busy;

    // Scan upward from last+1: first the masters above last, then wrap to 0..last.
    always_comb begin
        winner = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (req[j] && IDX_W'(j) <= last) winner = IDX_W'(j);
        end
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (req[j] && IDX_W'(j) > last) winner = IDX_W'(j);
        end
    end

    always_comb begin
        s_addr    = '0;
        s_wdata   = '0;
        s_byte_en = '0;
        s_ren     = 1'b0;
        s_wen     = 1'b0;
        m_rdata   = '0;
        m_busy    = '1;
        m_error   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (state == GRANT && gnt == IDX_W'(i)) begin
                s_addr    = m_addr[i*ADDR_W +: ADDR_W];
                s_wdata   = m_wdata[i*DATA_W +: DATA_W];
                s_byte_en = m_byte_en[i*BE_W +: BE_W];
                s_wen     = m_wen[i] & ~tmo;
                s_ren     = m_ren[i] & ~m_wen[i] & ~tmo;
                if (done) begin
                    m_busy[i]                  = 1'b0;
                    m_rdata[i*DATA_W +: DATA_W] = s_rdata;
                    m_error[i]                 = s_error;
                end else if (tmo) begin
                    m_busy[i]  = 1'b0;
                    m_error[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= IDX_W'(NUM_MASTERS - 1);
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= winner;
                        state <= GRANT;
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Normal completion has priority; the watchdog only fires while s_busy is high.
                    if (done || tmo) begin
                        last  <= gnt;
                        state <= IDLE;
                    end
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
                    else if (s_busy) begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Bench for generic_bus_arbiter: directed literal checks plus randomized traffic against a transfer-level model.
module tb_generic_bus_arbiter;
    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int BEW = N * BW;
    localparam int TO  = 8;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [BEW-1:0]  m_byte_en;
    logic [N-1:0]    m_ren;
    logic [N-1:0]    m_wen;
    logic [N*DW-1:0] m_rdata;
    logic [N-1:0]    m_busy;
    logic [N-1:0]    m_error;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [BW-1:0]   s_byte_en;
    logic            s_ren;
    logic            s_wen;
    logic [DW-1:0]   s_rdata;
    logic            s_busy;
    logic            s_error;

    generic_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
        .m_ren(m_ren), .m_wen(m_wen),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_error(m_error),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_byte_en(s_byte_en),
        .s_ren(s_ren), .s_wen(s_wen),
        .s_rdata(s_rdata), .s_busy(s_busy), .s_error(s_error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Transfer-level model: which master owns the bus (-1 = nobody), who was served last,
    // and how many busy cycles the current transfer has accumulated.
    int mgnt  = -1;
    int mlast = N - 1;
    int mcnt  = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mgnt  <= -1;
            mlast <= N - 1;
            mcnt  <= 0;
        end else if (mgnt < 0) begin
            for (int i = 1; i <= N; i++) begin
                if (m_ren[(mlast + i) % N] || m_wen[(mlast + i) % N]) begin
                    mgnt <= (mlast + i) % N;
                    mcnt <= 0;
                    break;
                end
            end
        end else begin
            if (!s_busy) begin
                mlast <= mgnt;
                mgnt  <= -1;
            end
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
            else if (mcnt == TO) begin
                mlast <= mgnt;
                mgnt  <= -1;
            end else begin
                mcnt <= mcnt + 1;
            end
`endif
        end
    end

    logic [AW-1:0]   e_sa;
    logic [DW-1:0]   e_sw;
    logic [BW-1:0]   e_sbe;
    logic            e_sren, e_swen;
    logic [N*DW-1:0] e_mr;
    logic [N-1:0]    e_mb, e_me;
    bit              e_tmo;

    always @(negedge CLK) begin
        if (!RST) begin
            e_sa = '0; e_sw = '0; e_sbe = '0; e_sren = 1'b0; e_swen = 1'b0;
            e_mr = '0; e_mb = '1; e_me = '0; e_tmo = 1'b0;
            if (mgnt >= 0) begin
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
                e_tmo = s_busy && (mcnt == TO);
`endif
                e_sa   = m_addr[mgnt*AW +: AW];
                e_sw   = m_wdata[mgnt*DW +: DW];
                e_sbe  = m_byte_en[mgnt*BW +: BW];
                e_swen = m_wen[mgnt] && !e_tmo;
                e_sren = m_ren[mgnt] && !m_wen[mgnt] && !e_tmo;
                if (!s_busy) begin
                    e_mb[mgnt]           = 1'b0;
                    e_mr[mgnt*DW +: DW]  = s_rdata;
                    e_me[mgnt]           = s_error;
                end else if (e_tmo) begin
                    e_mb[mgnt] = 1'b0;
                    e_me[mgnt] = 1'b1;
                end
            end
            check("slave_side", {s_addr, s_wdata, s_byte_en, s_ren, s_wen},
                  {e_sa, e_sw, e_sbe, e_sren, e_swen});
            check("master_side", {m_busy, m_error, m_rdata}, {e_mb, e_me, e_mr});
        end
    end

    int ord[$];
    int cyc[$];
    int exp_ord[6] = '{0, 1, 2, 0, 1, 2};
    int n;
    int held;

    initial begin
        m_addr = '0; m_wdata = '0; m_byte_en = '0; m_ren = '0; m_wen = '0;
        s_rdata = '0; s_busy = 1'b0; s_error = 1'b0;
        #12;
        check("rst_m_busy", m_busy, 3'b111);
        check("rst_s_ctrl", {s_ren, s_wen}, 2'b00);
        check("rst_s_addr", s_addr, 0);
        check("rst_m_rdata_err", {m_rdata, m_error}, 0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Round-robin under full contention with a zero-wait slave
        m_ren = 3'b111;
        for (int c = 0; c < 40 && ord.size() < 6; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!m_busy[i]) begin
                    ord.push_back(i);
                    cyc.push_back(c);
                end
            end
            if (ord.size() >= 6) m_ren = '0;
        end
        m_ren = '0;
        check("rr_count", ord.size(), 6);
        for (int k = 0; k < 6 && k < ord.size(); k++) begin
            check("rr_order", ord[k], exp_ord[k]);
            if (k > 0) check("rr_spacing", cyc[k] - cyc[k-1], 2);
        end
        tick();

        // Single read from master 1 with two wait cycles
        m_addr[1*AW +: AW] = 32'h100;
        m_ren[1] = 1'b1;
        s_busy = 1'b1;
        tick();
        check("rd_s_ctrl", {s_ren, s_wen}, 2'b10);
        check("rd_s_addr", s_addr, 32'h100);
        tick();
        check("rd_wait2", {s_ren, m_busy}, {1'b1, 3'b111});
        tick();
        s_busy = 1'b0;
        s_rdata = 32'hDEADBEEF;
        #1;
        check("rd_done_busy", {s_ren, m_busy}, {1'b1, 3'b101});
        check("rd_rdata", m_rdata, {32'h0, 32'hDEADBEEF, 32'h0});
        m_ren = '0;
        tick();
        check("rd_after", {m_busy, s_ren}, {3'b111, 1'b0});

        // Read+write collision on master 0
        m_ren[0] = 1'b1;
        m_wen[0] = 1'b1;
        m_byte_en[0 +: BW] = 4'b0011;
        m_wdata[0 +: DW] = 32'h12345678;
        s_busy = 1'b1;
        tick();
        check("col_ctrl", {s_ren, s_wen}, 2'b01);
        check("col_be_wdata", {s_byte_en, s_wdata}, {4'b0011, 32'h12345678});
        s_busy = 1'b0;
        #1;
        check("col_done", m_busy, 3'b110);
        m_ren = '0; m_wen = '0;
        tick();

        // Error passthrough on master 2, then a clean transfer on master 0
        m_ren[2] = 1'b1;
        s_busy = 1'b1;
        tick();
        s_busy = 1'b0;
        s_error = 1'b1;
        #1;
        check("err_flags", {m_busy, m_error}, {3'b011, 3'b100});
        m_ren = '0;
        tick();
        s_error = 1'b0;
        m_ren[0] = 1'b1;
        tick();
        check("err_next", {m_busy, m_error}, {3'b110, 3'b000});
        m_ren = '0;
        tick();

        // Reset in the middle of a transfer
        m_ren[1] = 1'b1;
        s_busy = 1'b1;
        tick();
        check("mr_pre", s_ren, 1'b1);
        #2 RST = 1'b1;
        #1;
        check("mr_ctrl", {s_ren, s_wen, m_busy}, {2'b00, 3'b111});
        check("mr_addr", s_addr, 0);
        m_addr[0 +: AW] = 32'hA0;
        m_ren = 3'b011;
        @(posedge CLK);
        #1 RST = 1'b0;
        tick();
        check("mr_first", s_addr, 32'hA0);
        s_busy = 1'b0;
        #1;
        check("mr_first_busy", m_busy, 3'b110);
        m_ren = '0;
        tick();

        // Slave that never finishes
        m_addr[2*AW +: AW] = 32'h300;
        m_ren = 3'b110;
        s_busy = 1'b1;
        tick();
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
        n = 0;
        while (m_busy == 3'b111 && n < 20) begin
            tick();
            n++;
        end
        check("to_cycles", n, 8);
        check("to_err", {m_busy, m_error, s_ren, s_wen}, {3'b101, 3'b010, 2'b00});
        m_ren[1] = 1'b0;
        tick();
        tick();
        check("to_next", s_addr, 32'h300);
        s_busy = 1'b0;
        #1;
        check("to_next_done", m_busy, 3'b011);
`else
        held = 0;
        repeat (40) begin
            tick();
            if (m_busy == 3'b111 && s_ren) held++;
        end
        check("no_to_hold", held, 40);
        s_busy = 1'b0;
        #1;
        check("no_to_release", m_busy, 3'b101);
`endif
        m_ren = '0;
        tick();

        // Randomized traffic
        repeat (600) begin
            tick();
            m_addr    = {$urandom(), $urandom(), $urandom()};
            m_wdata   = {$urandom(), $urandom(), $urandom()};
            m_byte_en = BEW'($urandom());
            m_ren     = N'($urandom()) & N'($urandom());
            m_wen     = N'($urandom()) & N'($urandom()) & N'($urandom());
            s_rdata   = $urandom();
            s_busy    = 1'($urandom());
            s_error   = 1'($urandom());
        end
        m_ren = '0; m_wen = '0; s_busy = 1'b0;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
